// File: rtl/uart2wifi_core_uart_tx_if.sv
// TX FIFO read-side handshake between the UART transmit engine (master) and the FIFO (slave).
interface uart2wifi_core_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_rdata;

  modport master (input fifo_empty, input fifo_rdata, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd);
endinterface

// File: rtl/uart2wifi_core_uart_tx.sv
// UART transmit engine: pops bytes from the TX FIFO and shifts them out LSB-first, 8N1 style.
// Define UART2WIFI_TX_PARITY_EN to insert a parity bit after the data bits.
module uart2wifi_core_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic baudtick,
  input  logic tx_en,
  uart2wifi_core_uart_tx_if.master fifo,
  output logic tx,
  output logic busy,
  output logic frame_done
);

  localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BCW = $clog2(DATA_W + 1);

`ifdef UART2WIFI_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
`ifdef UART2WIFI_TX_PARITY_EN
  logic              par;
`endif

  logic in_bit, bit_end;
  // Bit timing runs only while a bit is on the line; the LOAD-cycle tick is deliberately ignored.
  assign in_bit  = !(state inside {S_IDLE, S_FETCH, S_LOAD});
  assign bit_end = in_bit && baudtick && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      tx           <= 1'b1;
      fifo.fifo_rd <= 1'b0;
      frame_done   <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
`ifdef UART2WIFI_TX_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      fifo.fifo_rd <= 1'b0;
      frame_done   <= 1'b0;
      if (in_bit && baudtick)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (tx_en && !fifo.fifo_empty) begin
            fifo.fifo_rd <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          shreg    <= fifo.fifo_rdata;
`ifdef UART2WIFI_TX_PARITY_EN
          par      <= (^fifo.fifo_rdata) ^ (PARITY_ODD != 0);
`endif
          tick_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == BCW'(DATA_W - 1)) begin
              bit_cnt <= '0;
`ifdef UART2WIFI_TX_PARITY_EN
              tx      <= par;
              state   <= S_PARITY;
`else
              tx      <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              // tx takes the next bit now so the line moves exactly at the boundary
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
`ifdef UART2WIFI_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == BCW'(STOP_BITS - 1)) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
              // Back-to-back pop from the last stop tick keeps the line free of idle bits.
              if (tx_en && !fifo.fifo_empty) begin
                fifo.fifo_rd <= 1'b1;
                state        <= S_FETCH;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart2wifi_core_uart_tx.sv
// Directed bench for uart2wifi_core_uart_tx: FIFO model, baudtick every 10 clk, mid-bit line sampling.
module tb_uart2wifi_core_uart_tx;
  localparam int DW   = 8;
  localparam int OS   = 16;
  localparam int PODD = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baudtick = 1'b0;
  logic tx_en = 1'b0;
  logic tx, busy, frame_done;

  uart2wifi_core_uart_tx_if #(.DATA_W(DW)) fifo_if();

  uart2wifi_core_uart_tx #(
    .DATA_W(DW), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst(rst), .baudtick(baudtick), .tx_en(tx_en),
    .fifo(fifo_if), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];
  int edges[$];
  int cyc = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;
  int bad_pop = 0;
  int bcnt = 0;
  logic ptx = 1'b1;

  always @(negedge clk) begin
    if (bcnt == 9) begin bcnt <= 0; baudtick <= 1'b1; end
    else begin bcnt <= bcnt + 1; baudtick <= 1'b0; end
  end

  // FIFO model: pop on fifo_rd, data visible the clk after the pop strobe
  always @(posedge clk) begin
    if (fifo_if.fifo_rd === 1'b1) begin
      if (q.size() > 0) fifo_if.fifo_rdata <= q.pop_front();
      else bad_pop <= bad_pop + 1;
    end
  end

  always @(negedge clk) begin
    fifo_if.fifo_empty <= (q.size() == 0);
    cyc <= cyc + 1;
    ptx <= tx;
    if (tx !== ptx) edges.push_back(cyc);
    if (fifo_if.fifo_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the start bit, then sample every bit near its middle.
  task automatic frame(input string tag, input logic [31:0] exp, input int nbits);
    int n = 0;
    while (tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      check({tag, "_start_timeout"}, 0, 1);
      return;
    end
    repeat (80) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      check($sformatf("%s_bit%0d", tag, i), int'(tx), int'(exp[i]));
      if (i < nbits - 1) repeat (160) @(negedge clk);
    end
  endtask

  int rd0, fd0, gap, w1, w2;

  initial begin
    // 1: reset holds the line idle even with data waiting
    tx_en = 1'b1;
    q.push_back(8'h11);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_tx", int'(tx), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_rd", int'(fifo_if.fifo_rd), 0);
      check("rst_fd", int'(frame_done), 0);
    end
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx", int'(tx), 1);
    check("idle_busy", int'(busy), 0);

    // 2: single byte A5
    rd0 = rd_cnt; fd0 = fd_cnt;
    edges.delete();
    q.push_back(8'hA5);
    frame("t2", 32'h34A, 10);
    repeat (200) @(negedge clk);
    w1 = (edges.size() >= 4) ? edges[2] - edges[1] : 0;
    w2 = (edges.size() >= 4) ? edges[3] - edges[2] : 0;
    check("t2_bit_w0", w1, 160);
    check("t2_bit_w1", w2, 160);
    check("t2_rd", rd_cnt - rd0, 1);
    check("t2_fd", fd_cnt - fd0, 1);
    check("t2_busy", int'(busy), 0);
    check("t2_tx", int'(tx), 1);

    // 3: back-to-back 00 then FF
    rd0 = rd_cnt; fd0 = fd_cnt;
    edges.delete();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    frame("t3", 32'hFFA00, 20);
    repeat (200) @(negedge clk);
    gap = (edges.size() >= 3) ? edges[2] - edges[1] : 0;
    check("t3_stop_to_start", gap, 162);
    check("t3_rd", rd_cnt - rd0, 2);
    check("t3_fd", fd_cnt - fd0, 2);
    check("t3_busy", int'(busy), 0);

    // 4: tx_en dropped mid-DATA with a second byte queued
    rd0 = rd_cnt; fd0 = fd_cnt;
    q.push_back(8'h55);
    q.push_back(8'h81);
    fork
      frame("t4", 32'h2AA, 10);
      begin repeat (600) @(negedge clk); tx_en = 1'b0; end
    join
    repeat (400) @(negedge clk);
    check("t4_rd", rd_cnt - rd0, 1);
    check("t4_fd", fd_cnt - fd0, 1);
    check("t4_tx", int'(tx), 1);
    check("t4_busy", int'(busy), 0);
    check("t4_left", q.size(), 1);
    q.delete();
    repeat (3) @(negedge clk);

    // 5: reset mid-DATA of 3C, then 96 goes out whole
    rd0 = rd_cnt;
    q.push_back(8'h3C);
    q.push_back(8'h96);
    tx_en = 1'b1;
    repeat (700) @(negedge clk);
    check("t5_busy_pre", int'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_tx", int'(tx), 1);
    check("t5_rst_busy", int'(busy), 0);
    rst = 1'b1;
    fd0 = fd_cnt;
    frame("t5", 32'h32C, 10);
    repeat (200) @(negedge clk);
    check("t5_rd", rd_cnt - rd0, 2);
    check("t5_fd", fd_cnt - fd0, 1);
    check("t5_busy", int'(busy), 0);

    // 6: 07 followed by 00 shows whether a parity bit sits before the stop bit
    rd0 = rd_cnt;
    q.push_back(8'h07);
    q.push_back(8'h00);
`ifdef UART2WIFI_TX_PARITY_EN
    if (PODD == 0) frame("t6", 32'h20060E, 22);
    else           frame("t6", 32'h30040E, 22);
`else
    frame("t6", 32'h8020E, 20);
`endif
    repeat (300) @(negedge clk);
    check("t6_rd", rd_cnt - rd0, 2);
    check("t6_busy", int'(busy), 0);

    check("no_empty_pop", bad_pop, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
